// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-approach traffic controller.
// Holds the car and walker lamp encodings, the controller state enum and
// a helper that sizes the approach-index bus.
package traffic_pkg;

    // Car lamp nibble per approach
    localparam logic [3:0] C_NONE   = 4'b0000;
    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_LEFT   = 4'b0010;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_RED    = 4'b1000;

    // Walker lamp pair per approach
    localparam logic [1:0] W_NONE  = 2'b00;
    localparam logic [1:0] W_GREEN = 2'b01;
    localparam logic [1:0] W_RED   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YEL1,
        ST_LEFT,
        ST_YEL2,
        ST_ALLRED,
        ST_NFLASH
    } state_e;

    // Width of the approach index; never narrower than one bit.
    function automatic int app_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase down-counter for the traffic controller.
// Ports:
//   clk, rst       clock, async active-high reset (count -> 0)
//   load_i         load load_val_i this cycle (has priority over tick)
//   load_val_i     value loaded on phase entry (phase length - 1)
//   tick_i         timing strobe; count decrements on it, saturating at 0
//   value_o        current count (ticks left in the phase)
//   zero_o         count is zero: the next tick ends the phase
module traffic_phase_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic [TMR_W-1:0] value_o,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (tick_i && (cnt_q != '0))
            cnt_d = cnt_q - TMR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-approach round-robin intersection controller.
// Each approach runs GREEN -> YELLOW -> (LEFT -> YELLOW if enabled) -> ALL-RED,
// with pedestrian service during the served approach's green and a night
// flashing-yellow mode entered at the end of an all-red phase.
// Ports:
//   clk, reset         clock, async active-high reset
//   i_start            run enable; low forces IDLE and blanks every output
//   i_tick             timing strobe; phases advance only on it
//   i_night            request night flash mode
//   i_ped_req          per-approach pedestrian button (level or pulse)
//   o_car_traffic      4 bits per approach: GREEN/LEFT/YELLOW/RED one-hot
//   o_walker_traffic   2 bits per approach: RED 10, GREEN 01, NONE 00
//   o_app              active approach index
//   o_remain           ticks left in the current phase
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int             N_APP     = 2,
    parameter int             TMR_W     = 8,
    parameter int             T_GREEN   = 20,
    parameter int             T_YELLOW  = 2,
    parameter int             T_LEFT    = 10,
    parameter int             T_ALLRED  = 2,
    parameter int             T_WALK    = 8,
    parameter int             T_FLASH   = 6,
    parameter logic [N_APP-1:0] LEFT_MASK = {N_APP{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic                       i_tick,
    input  logic                       i_night,
    input  logic [N_APP-1:0]           i_ped_req,
    output logic [4*N_APP-1:0]         o_car_traffic,
    output logic [2*N_APP-1:0]         o_walker_traffic,
    output logic [app_w(N_APP)-1:0]    o_app,
    output logic [TMR_W-1:0]           o_remain
);

    localparam int               AW        = app_w(N_APP);
    localparam logic [AW-1:0]    APP_LAST  = AW'(N_APP - 1);
    localparam logic [TMR_W-1:0] LD_GREEN  = TMR_W'(T_GREEN - 1);
    localparam logic [TMR_W-1:0] LD_YELLOW = TMR_W'(T_YELLOW - 1);
    localparam logic [TMR_W-1:0] LD_LEFT   = TMR_W'(T_LEFT - 1);
    localparam logic [TMR_W-1:0] LD_ALLRED = TMR_W'(T_ALLRED - 1);
    localparam logic [TMR_W-1:0] WALK_END  = TMR_W'(T_WALK);
    localparam logic [TMR_W-1:0] FLASH_END = TMR_W'(T_WALK + T_FLASH);

    state_e           state_q, state_d;
    logic [AW-1:0]    app_q, app_d, app_nxt;
    logic             first_q, first_d;     // next GREEN restarts at approach 0
    logic             flash_q, flash_d;
    logic             served_q, served_d;   // current green carries a ped service
    logic [N_APP-1:0] ped_q, ped_d;

    logic             tmr_load, tmr_zero, phase_end;
    logic [TMR_W-1:0] tmr_val, tmr_value;

    traffic_phase_timer #(.TMR_W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (i_tick),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    assign phase_end = i_tick && tmr_zero;
    assign app_nxt   = (first_q || (app_q == APP_LAST)) ? '0 : app_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        app_d    = app_q;
        first_d  = first_q;
        flash_d  = flash_q;
        served_d = served_q;
        ped_d    = ped_q | i_ped_req;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!i_start) begin
            state_d  = ST_IDLE;
            flash_d  = 1'b0;
            served_d = 1'b0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ALLRED;
                    app_d    = '0;
                    first_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ALLRED;
                end
                ST_GREEN: if (phase_end) begin
                    state_d  = ST_YEL1;
                    served_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_YELLOW;
                end
                ST_YEL1: if (phase_end) begin
                    tmr_load = 1'b1;
                    if (LEFT_MASK[app_q]) begin
                        state_d = ST_LEFT;
                        tmr_val = LD_LEFT;
                    end else begin
                        state_d = ST_ALLRED;
                        tmr_val = LD_ALLRED;
                    end
                end
                ST_LEFT: if (phase_end) begin
                    state_d  = ST_YEL2;
                    tmr_load = 1'b1;
                    tmr_val  = LD_YELLOW;
                end
                ST_YEL2: if (phase_end) begin
                    state_d  = ST_ALLRED;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ALLRED;
                end
                ST_ALLRED: if (phase_end) begin
                    tmr_load = 1'b1;
                    if (i_night) begin
                        state_d = ST_NFLASH;
                        flash_d = 1'b0;
                    end else begin
                        state_d  = ST_GREEN;
                        app_d    = app_nxt;
                        first_d  = 1'b0;
                        tmr_val  = LD_GREEN;
                        // A press in this very cycle is folded into this service.
                        served_d = ped_d[app_nxt];
                        ped_d[app_nxt] = 1'b0;
                    end
                end
                ST_NFLASH: if (i_tick) begin
                    if (!i_night) begin
                        state_d  = ST_ALLRED;
                        app_d    = '0;
                        first_d  = 1'b1;
                        flash_d  = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = LD_ALLRED;
                    end else begin
                        flash_d = ~flash_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            app_q    <= '0;
            first_q  <= 1'b0;
            flash_q  <= 1'b0;
            served_q <= 1'b0;
            ped_q    <= '0;
        end else begin
            state_q  <= state_d;
            app_q    <= app_d;
            first_q  <= first_d;
            flash_q  <= flash_d;
            served_q <= served_d;
            ped_q    <= ped_d;
        end
    end

    // ---- output decode ----
    logic [N_APP-1:0][3:0] car;
    logic [N_APP-1:0][1:0] wlk;
    logic [TMR_W-1:0]      elapsed, fl_diff;
    logic [3:0]            colour;
    logic [1:0]            walk_lamp;
    logic                  active;

    assign active  = i_start && (state_q != ST_IDLE);
    // Green elapsed ticks derived from the down-counter.
    assign elapsed = LD_GREEN - tmr_value;
    assign fl_diff = elapsed - WALK_END;

    always_comb begin
        colour = C_YELLOW;
        case (state_q)
            ST_GREEN: colour = C_GREEN;
            ST_LEFT:  colour = C_LEFT;
            default:  colour = C_YELLOW;
        endcase
        walk_lamp = W_RED;
        if (elapsed < WALK_END)       walk_lamp = W_GREEN;
        else if (elapsed < FLASH_END) walk_lamp = fl_diff[0] ? W_NONE : W_GREEN;
        car = '0;
        wlk = '0;
        if (active) begin
            for (int k = 0; k < N_APP; k++) begin
                car[k] = C_RED;
                wlk[k] = W_RED;
                if (state_q == ST_NFLASH) begin
                    car[k] = flash_q ? C_YELLOW : C_NONE;
                    wlk[k] = W_NONE;
                end else if (state_q != ST_ALLRED && app_q == AW'(k)) begin
                    car[k] = colour;
                    if (state_q == ST_GREEN && served_q) wlk[k] = walk_lamp;
                end
            end
        end
    end

    assign o_car_traffic    = car;
    assign o_walker_traffic = wlk;
    assign o_app            = active ? app_q : '0;
    assign o_remain         = active ? tmr_value : '0;

endmodule
